// File: rtl/seg_scan_mux.sv
// Purpose: time-multiplexes four BCD digits (MM:SS) onto one decoder and drives active-low anodes.
// Latency: digit/anode registered, 1 cycle after pos/scan_cnt/inputs; GUARD off-cycles open each slot.
// Backpressure: none; free-running scan, inputs sampled every cycle, rst has priority.
module seg_scan_mux #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       adj_en,
  input  logic       adj_sel,
  input  logic       blink_tick,
  output logic [3:0] digit,
  output logic [3:0] anode
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    pos;
  logic          blink_ph;

  logic          slot_end;
  logic          in_guard;
  logic          in_sel_pair;
  logic          blanked;
  logic [3:0]    digit_nxt;
  logic [3:0]    anode_nxt;

  // Next output values derived from the current slot, blink phase and live inputs
  always_comb begin
    slot_end    = (scan_cnt == CW'(SCAN_DIV - 1));
    in_guard    = (GUARD > 0) && (scan_cnt < CW'(GUARD));
    // Seconds pair is positions 0,1 (pos[1]=0); minutes pair is positions 2,3
    in_sel_pair = adj_sel ? ~pos[1] : pos[1];
    blanked     = adj_en & blink_ph & in_sel_pair;
    unique case (pos)
      2'd0:    digit_nxt = sec_ones;
      2'd1:    digit_nxt = sec_tens;
      2'd2:    digit_nxt = min_ones;
      default: digit_nxt = min_tens;
    endcase
    // digit and anode come from the same pos, so a lit anode never shows another position's value
    if (in_guard || blanked) begin
      anode_nxt = 4'b1111;
    end else begin
      anode_nxt = ~(4'b0001 << pos);
    end
  end

  // Slot counter and digit position: pos advances when the slot counter wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      pos      <= 2'd0;
    end else if (slot_end) begin
      scan_cnt <= '0;
      pos      <= pos + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Blink phase: toggles on tick in adjust mode, held low outside it; new phase is seen by the next output
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_ph <= 1'b0;
    end else if (!adj_en) begin
      blink_ph <= 1'b0;
    end else if (blink_tick) begin
      blink_ph <= ~blink_ph;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= 4'h0;
      anode <= 4'b1111;
    end else begin
      digit <= digit_nxt;
      anode <= anode_nxt;
    end
  end

endmodule
